// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative fixed-point divider.
package divider_pkg;

    // Widest operand the helper functions handle
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Largest positive value of a w-bit two's complement number, zero extended
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative w-bit value, which is also its magnitude
    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // Magnitude of a sign-extended value; the most negative operand still fits unsigned
    function automatic logic [MAX_W-1:0] abs_u(input logic signed [MAX_W-1:0] v);
        return v[MAX_W-1] ? (64'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
    parameter int D_W = 16
) (
    input  logic [D_W-1:0] part_rem,
    input  logic [D_W-1:0] divisor,
    input  logic           shift_in,
    output logic [D_W-1:0] next_rem,
    output logic           q_bit
);
    // The partial remainder stays below the divisor magnitude (at most 2^(D_W-1)),
    // so the shifted candidate always fits in D_W+1 bits and bit D_W is a clean borrow.
    logic [D_W:0] cand;
    logic [D_W:0] diff;

    // Trial subtraction; keep the difference only when it does not borrow
    always_comb begin
        cand  = {part_rem, shift_in};
        diff  = cand - {1'b0, divisor};
        q_bit = ~diff[D_W];
        if (q_bit) begin
            next_rem = diff[D_W-1:0];
        end else begin
            next_rem = cand[D_W-1:0];
        end
    end

endmodule

// File: rtl/divider_fx.sv
// Iterative signed fixed-point divider: Q = (dividend << FRAC_W) / divisor,
// truncated toward zero, with remainder, divide-by-zero and saturation flags.
module divider_fx
    import divider_pkg::*;
#(
    parameter int D_W    = 16,
    parameter int FRAC_W = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    output logic           in_ready,
    input  logic [D_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_vld,
    input  logic           out_ready,
    output logic [D_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div0,
    output logic           ovf
);
    localparam int N     = D_W + FRAC_W;
    localparam int CNT_W = $clog2(N);
    localparam int PR_W  = N + D_W;

    // Magnitude limits for the unsigned quotient, and the saturated output codes
    localparam logic [N-1:0]   POS_LIM = N'(sat_max(D_W));
    localparam logic [N-1:0]   NEG_LIM = N'(sat_min(D_W));
    localparam logic [D_W-1:0] Q_MAX   = D_W'(sat_max(D_W));
    localparam logic [D_W-1:0] Q_MIN   = D_W'(sat_min(D_W));

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [PR_W-1:0]  pr;        // {remainder, dividend bits / quotient bits}
    logic [D_W-1:0]   dsr_mag;
    logic             dvd_neg;
    logic             dsr_neg;

    logic             accept;
    logic [D_W-1:0]   dvd_mag_in;
    logic [D_W-1:0]   dsr_mag_in;
    logic [N-1:0]     scaled_in;
    logic [D_W-1:0]   step_rem;
    logic             step_q;
    logic [N-1:0]     q_mag;
    logic [D_W-1:0]   fin_q;
    logic [D_W-1:0]   fin_r;
    logic             fin_ovf;

    assign accept     = in_vld & in_ready;
    assign dvd_mag_in = D_W'(abs_u({{(MAX_W-D_W){dividend[D_W-1]}}, dividend}));
    assign dsr_mag_in = D_W'(abs_u({{(MAX_W-D_W){divisor[D_W-1]}}, divisor}));
    assign scaled_in  = N'(dvd_mag_in) << FRAC_W;

    div_restore_step #(.D_W(D_W)) u_step (
        .part_rem (pr[PR_W-1:N]),
        .divisor  (dsr_mag),
        .shift_in (pr[N-1]),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    // Quotient magnitude after this step: dividend bits move up, new quotient bit enters at bit 0
    assign q_mag = {pr[N-2:0], step_q};

    // Sign correction and saturation of the result produced by the final step
    always_comb begin
        fin_q   = {D_W{1'b0}};
        fin_r   = {D_W{1'b0}};
        fin_ovf = 1'b0;
        if (dvd_neg ^ dsr_neg) begin
            if (q_mag > NEG_LIM) begin
                fin_q   = Q_MIN;
                fin_ovf = 1'b1;
            end else begin
                fin_q = {D_W{1'b0}} - q_mag[D_W-1:0];
                fin_r = dvd_neg ? ({D_W{1'b0}} - step_rem) : step_rem;
            end
        end else begin
            if (q_mag > POS_LIM) begin
                fin_q   = Q_MAX;
                fin_ovf = 1'b1;
            end else begin
                fin_q = q_mag[D_W-1:0];
                fin_r = dvd_neg ? ({D_W{1'b0}} - step_rem) : step_rem;
            end
        end
    end

    // Control FSM with operand capture, iteration counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= {CNT_W{1'b0}};
            pr        <= {PR_W{1'b0}};
            dsr_mag   <= {D_W{1'b0}};
            dvd_neg   <= 1'b0;
            dsr_neg   <= 1'b0;
            in_ready  <= 1'b1;
            out_vld   <= 1'b0;
            quotient  <= {D_W{1'b0}};
            remainder <= {D_W{1'b0}};
            div0      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_neg  <= dividend[D_W-1];
                        dsr_neg  <= divisor[D_W-1];
                        dsr_mag  <= dsr_mag_in;
                        pr       <= {{D_W{1'b0}}, scaled_in};
                        in_ready <= 1'b0;
                        ovf      <= 1'b0;
                        if (divisor == {D_W{1'b0}}) begin
                            // Result is known now; out_vld follows one cycle later in DONE
                            state     <= DONE;
                            div0      <= 1'b1;
                            quotient  <= dividend[D_W-1] ? Q_MIN : Q_MAX;
                            remainder <= {D_W{1'b0}};
                        end else begin
                            state <= CALC;
                            div0  <= 1'b0;
                            cnt   <= CNT_W'(N - 1);
                        end
                    end
                end
                CALC: begin
                    pr <= {step_rem, q_mag};
                    if (cnt == {CNT_W{1'b0}}) begin
                        state     <= DONE;
                        out_vld   <= 1'b1;
                        quotient  <= fin_q;
                        remainder <= fin_r;
                        ovf       <= fin_ovf;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!out_vld) begin
                        out_vld <= 1'b1;
                    end else if (out_ready) begin
                        state    <= IDLE;
                        out_vld  <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    out_vld  <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_fx.sv
// Self-checking bench for divider_fx: directed corner cases plus random operands
// compared against a plain-arithmetic reference, on an integer and a Q.8 instance.
module tb_divider_fx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld    [2];
    logic        out_ready [2];
    logic [15:0] dvd       [2];
    logic [15:0] dsr       [2];
    wire         in_ready  [2];
    wire         out_vld   [2];
    wire  [15:0] quot      [2];
    wire  [15:0] rem       [2];
    wire         div0      [2];
    wire         ovf       [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divider_fx #(.D_W(16), .FRAC_W(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld[0]), .in_ready(in_ready[0]),
        .dividend(dvd[0]), .divisor(dsr[0]), .out_vld(out_vld[0]), .out_ready(out_ready[0]),
        .quotient(quot[0]), .remainder(rem[0]), .div0(div0[0]), .ovf(ovf[0])
    );

    divider_fx #(.D_W(16), .FRAC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld[1]), .in_ready(in_ready[1]),
        .dividend(dvd[1]), .divisor(dsr[1]), .out_vld(out_vld[1]), .out_ready(out_ready[1]),
        .quotient(quot[1]), .remainder(rem[1]), .div0(div0[1]), .ovf(ovf[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference: scale, divide with truncation toward zero, then apply flag rules
    function automatic void model(input int f, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic d0, output logic ov);
        longint sa, sb, qq, rr;
        sa = longint'($signed(a)) * (longint'(1) << f);
        sb = longint'($signed(b));
        d0 = 1'b0;
        ov = 1'b0;
        if (sb == 64'sd0) begin
            d0 = 1'b1;
            qq = (sa >= 64'sd0) ? 64'sd32767 : -64'sd32768;
            rr = 64'sd0;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            if (qq > 64'sd32767) begin
                qq = 64'sd32767; rr = 64'sd0; ov = 1'b1;
            end else if (qq < -64'sd32768) begin
                qq = -64'sd32768; rr = 64'sd0; ov = 1'b1;
            end
        end
        q = 16'(qq);
        r = 16'(rr);
    endfunction

    // One transaction on instance s; hold > 0 keeps out_ready low that many cycles in DONE
    task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b, input int hold);
        int          f;
        int          lat;
        int          waitc;
        logic [15:0] eq, er;
        logic        ed, eo;
        f = (s == 0) ? 0 : 8;
        model(f, a, b, eq, er, ed, eo);
        @(negedge clk);
        waitc = 0;
        while (in_ready[s] !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("in_ready_idle", 32'(in_ready[s]), 32'd1);
        in_vld[s]    = 1'b1;
        dvd[s]       = a;
        dsr[s]       = b;
        out_ready[s] = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
        in_vld[s] = 1'b0;
        dvd[s]    = 16'($urandom);
        dsr[s]    = 16'($urandom);
        lat = 0;
        while (out_vld[s] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), ed ? 32'd1 : 32'(16 + f));
        chk("out_vld", 32'(out_vld[s]), 32'd1);
        chk("quotient", 32'(quot[s]), 32'(eq));
        chk("remainder", 32'(rem[s]), 32'(er));
        chk("div0", 32'(div0[s]), 32'(ed));
        chk("ovf", 32'(ovf[s]), 32'(eo));
        chk("in_ready_busy", 32'(in_ready[s]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_vld", 32'(out_vld[s]), 32'd1);
            chk("hold_q", 32'(quot[s]), 32'(eq));
            chk("hold_r", 32'(rem[s]), 32'(er));
            chk("hold_ready", 32'(in_ready[s]), 32'd0);
        end
        out_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[s] = 1'b0;
        chk("out_vld_drop", 32'(out_vld[s]), 32'd0);
        chk("in_ready_back", 32'(in_ready[s]), 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_vld[s]    = 1'b0;
            out_ready[s] = 1'b0;
            dvd[s]       = 16'd0;
            dsr[s]       = 16'd0;
        end
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", 32'(in_ready[s]), 32'd1);
            chk("rst_out_vld", 32'(out_vld[s]), 32'd0);
            chk("rst_quot", 32'(quot[s]), 32'd0);
            chk("rst_rem", 32'(rem[s]), 32'd0);
            chk("rst_div0", 32'(div0[s]), 32'd0);
            chk("rst_ovf", 32'(ovf[s]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Integer division, all sign combinations
        run_op(0, 16'd100, 16'd7, 0);
        run_op(0, -16'sd100, 16'd7, 0);
        run_op(0, 16'd100, -16'sd7, 0);
        run_op(0, -16'sd100, -16'sd7, 0);
        // Overflow boundary and most negative operand
        run_op(0, 16'h8000, 16'hFFFF, 0);
        run_op(0, 16'h8000, 16'h0001, 0);
        run_op(0, 16'h7FFF, 16'h8000, 0);
        // Divide by zero
        run_op(0, 16'd5, 16'd0, 0);
        run_op(0, -16'sd5, 16'd0, 0);
        run_op(0, 16'd0, 16'd0, 0);
        // Result held while downstream stalls
        run_op(0, 16'd100, 16'd7, 20);
        // Fractional quotient
        run_op(1, 16'd256, 16'd768, 0);
        run_op(1, 16'd32767, 16'd1, 0);
        run_op(1, -16'sd256, 16'd768, 0);
        run_op(1, -16'sd3, 16'd0, 0);

        // Reset in the middle of a calculation
        @(negedge clk);
        in_vld[0] = 1'b1;
        dvd[0]    = 16'd1000;
        dsr[0]    = 16'd3;
        @(posedge clk);
        #1;
        in_vld[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", 32'(out_vld[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_result", 32'(out_vld[0]), 32'd0);
        chk("midrst_idle", 32'(in_ready[0]), 32'd1);

        // Random integer operands with biased corners
        for (int k = 0; k < 1500; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       a = 16'h8000;
                1:       b = 16'h0001;
                2:       b = 16'hFFFF;
                3:       b = 16'($urandom_range(1, 15));
                default: b = b;
            endcase
            if (b == 16'd0) b = 16'd1;
            run_op(0, a, b, 0);
        end

        // Random fractional operands, divisor zero allowed
        for (int k = 0; k < 150; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 600));
            run_op(1, a, b, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
